// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared defaults, counter width and address-width helper
package regfile_scoreboard_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 16;
   localparam int NREAD_DEF = 4;
   localparam int CNT_W     = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic int addr_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - writeback/forward/issue/read bundle for the scoreboarded regfile
interface regfile_scoreboard_if
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = NREAD_DEF
);
   localparam int AW = addr_width(NREGS);

   logic                  wb_en;
   logic [AW-1:0]         wb_addr;
   logic [XLEN-1:0]       wb_data;
   logic                  exe_en;
   logic [AW-1:0]         exe_addr;
   logic [XLEN-1:0]       exe_data;
   logic                  issue_en;
   logic [AW-1:0]         issue_addr;
   logic [NREAD-1:0]      rd_req;
   logic [NREAD*AW-1:0]   rd_addr;
   logic [NREAD*XLEN-1:0] rd_data;
   logic [NREAD-1:0]      rd_fwd;
   logic [NREAD-1:0]      rd_ready;
   logic                  stall;
   logic [NREGS-1:0]      pending;

   modport master (
      output wb_en, wb_addr, wb_data, exe_en, exe_addr, exe_data,
             issue_en, issue_addr, rd_req, rd_addr,
      input  rd_data, rd_fwd, rd_ready, stall, pending
   );

   modport slave (
      input  wb_en, wb_addr, wb_data, exe_en, exe_addr, exe_data,
             issue_en, issue_addr, rd_req, rd_addr,
      output rd_data, rd_fwd, rd_ready, stall, pending
   );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// rtl/regfile_scoreboard_read_port.sv - one read port: exe > wb > storage bypass mux and readiness
module regfile_read_port #(
   parameter int XLEN = 32,
   parameter int AW   = 4
) (
   input  logic [AW-1:0]   rd_addr_i,
   input  logic            exe_en_i,
   input  logic [AW-1:0]   exe_addr_i,
   input  logic [XLEN-1:0] exe_data_i,
   input  logic            wb_en_i,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic [XLEN-1:0] stor_data_i,
   input  logic            pend_i,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_fwd_o,
   output logic            rd_ready_o
);
   logic nz;
   logic exe_hit;
   logic wb_hit;

   assign nz      = (rd_addr_i != '0);
   assign exe_hit = nz && exe_en_i && (exe_addr_i == rd_addr_i);
   assign wb_hit  = nz && wb_en_i && (wb_addr_i == rd_addr_i);

   assign rd_data_o  = exe_hit ? exe_data_i : (wb_hit ? wb_data_i : stor_data_i);
   assign rd_fwd_o   = exe_hit || wb_hit;
   assign rd_ready_o = !nz || !pend_i || rd_fwd_o;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register in-flight counters and bypassed read ports
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = NREAD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = addr_width(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [CNT_W-1:0] cnt_q  [NREGS];
   logic [CNT_W-1:0] cnt_d  [NREGS];
   logic [NREGS-1:0] pend_vec;

   logic wb_live;
   logic iss_live;
   logic iss_full;

   assign wb_live  = bus.wb_en && (bus.wb_addr != '0);
   assign iss_live = bus.issue_en && (bus.issue_addr != '0);
   assign iss_full = iss_live && (cnt_q[bus.issue_addr] == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wb_live) begin
         regs_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Issue and writeback to the same register in one cycle cancel out.
   always_comb begin
      for (int i = 0; i < NREGS; i++) cnt_d[i] = cnt_q[i];
      for (int i = 1; i < NREGS; i++) begin
         if (iss_live && (bus.issue_addr == AW'(i)) &&
             !(wb_live && (bus.wb_addr == AW'(i)))) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (wb_live && (bus.wb_addr == AW'(i)) &&
                      !(iss_live && (bus.issue_addr == AW'(i)))) begin
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      pend_vec = '0;
      for (int i = 1; i < NREGS; i++) pend_vec[i] = (cnt_q[i] != '0);
   end

   logic [NREAD*XLEN-1:0] rd_data_w;
   logic [NREAD-1:0]      rd_fwd_w;
   logic [NREAD-1:0]      rd_ready_w;

   for (genvar k = 0; k < NREAD; k++) begin : g_port
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] stor;

      assign addr = bus.rd_addr[k*AW +: AW];
      assign stor = (addr == '0) ? '0 : regs_q[addr];

      regfile_read_port #(
         .XLEN(XLEN),
         .AW  (AW)
      ) u_port (
         .rd_addr_i  (addr),
         .exe_en_i   (bus.exe_en),
         .exe_addr_i (bus.exe_addr),
         .exe_data_i (bus.exe_data),
         .wb_en_i    (bus.wb_en),
         .wb_addr_i  (bus.wb_addr),
         .wb_data_i  (bus.wb_data),
         .stor_data_i(stor),
         .pend_i     (pend_vec[addr]),
         .rd_data_o  (rd_data_w[k*XLEN +: XLEN]),
         .rd_fwd_o   (rd_fwd_w[k]),
         .rd_ready_o (rd_ready_w[k])
      );
   end

   assign bus.rd_data  = rd_data_w;
   assign bus.rd_fwd   = rd_fwd_w;
   assign bus.rd_ready = rd_ready_w;
   assign bus.stall    = iss_full || (|(bus.rd_req & ~rd_ready_w));
   assign bus.pending  = pend_vec;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed stimulus with queued expectations checked by a negedge monitor
module tb_regfile_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREGS = 16;
   localparam int NREAD = 4;

   localparam logic [4:0] ALL = 5'h1f;
   localparam logic [4:0] SP  = 5'h18;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      string        name;
      logic [127:0] data;
      logic [3:0]   fwd;
      logic [3:0]   rdy;
      logic         stall;
      logic [15:0]  pend;
      logic [4:0]   chk;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   exp_valid = 1'b0;
   int   checks    = 0;
   int   failures  = 0;

   function automatic logic [127:0] d4(input logic [31:0] v);
      return {4{v}};
   endfunction

   function automatic logic [15:0] a4(input logic [3:0] a);
      return {4{a}};
   endfunction

   task automatic idle();
      bus.wb_en      = 1'b0;
      bus.wb_addr    = '0;
      bus.wb_data    = '0;
      bus.exe_en     = 1'b0;
      bus.exe_addr   = '0;
      bus.exe_data   = '0;
      bus.issue_en   = 1'b0;
      bus.issue_addr = '0;
      bus.rd_req     = '0;
      bus.rd_addr    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      idle();
   endtask

   task automatic expect_out(input string n, input logic [4:0] chk, input logic [127:0] d,
                             input logic [3:0] f, input logic [3:0] r, input logic s,
                             input logic [15:0] p);
      exp_t e;
      e.name  = n;
      e.chk   = chk;
      e.data  = d;
      e.fwd   = f;
      e.rdy   = r;
      e.stall = s;
      e.pend  = p;
      q.push_back(e);
      exp_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (exp_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL underflow: output presented with no expectation queued");
         end else begin
            cur = q.pop_front();
            if (cur.chk[0]) begin
               checks++;
               if (bus.rd_data !== cur.data) begin
                  failures++;
                  $display("FAIL %s rd_data got=%h exp=%h", cur.name, bus.rd_data, cur.data);
               end
            end
            if (cur.chk[1]) begin
               checks++;
               if (bus.rd_fwd !== cur.fwd) begin
                  failures++;
                  $display("FAIL %s rd_fwd got=%b exp=%b", cur.name, bus.rd_fwd, cur.fwd);
               end
            end
            if (cur.chk[2]) begin
               checks++;
               if (bus.rd_ready !== cur.rdy) begin
                  failures++;
                  $display("FAIL %s rd_ready got=%b exp=%b", cur.name, bus.rd_ready, cur.rdy);
               end
            end
            if (cur.chk[3]) begin
               checks++;
               if (bus.stall !== cur.stall) begin
                  failures++;
                  $display("FAIL %s stall got=%b exp=%b", cur.name, bus.stall, cur.stall);
               end
            end
            if (cur.chk[4]) begin
               checks++;
               if (bus.pending !== cur.pend) begin
                  failures++;
                  $display("FAIL %s pending got=%h exp=%h", cur.name, bus.pending, cur.pend);
               end
            end
         end
         exp_valid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // every address on 4 ports while held in reset
      for (int c = 0; c < 4; c++) begin
         bus.rd_req  = 4'hf;
         bus.rd_addr = {4'(4*c+3), 4'(4*c+2), 4'(4*c+1), 4'(4*c)};
         expect_out($sformatf("reset_read%0d", c), ALL, '0, 4'h0, 4'hf, 1'b0, 16'h0);
         tick();
      end
      rst_n = 1'b1;

      // issue r5, hazard, wb bypass, storage read
      bus.issue_en = 1'b1; bus.issue_addr = 4'd5;
      expect_out("issue_r5", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0000);
      tick();
      bus.rd_req = 4'h1; bus.rd_addr = a4(4'd5);
      expect_out("r5_hazard", 5'h1c, '0, 4'h0, 4'h0, 1'b1, 16'h0020);
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'hDEADBEEF;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd5);
      expect_out("r5_wb_bypass", ALL, d4(32'hDEADBEEF), 4'hf, 4'hf, 1'b0, 16'h0020);
      tick();
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd5);
      expect_out("r5_storage", ALL, d4(32'hDEADBEEF), 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();

      // exe bypass has priority over wb
      bus.exe_en = 1'b1; bus.exe_addr = 4'd3; bus.exe_data = 32'h11;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h22;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd3);
      expect_out("r3_exe_over_wb", ALL, d4(32'h11), 4'hf, 4'hf, 1'b0, 16'h0);
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h33;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd3);
      expect_out("r3_wb_only", ALL, d4(32'h33), 4'hf, 4'hf, 1'b0, 16'h0);
      tick();
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd3);
      expect_out("r3_storage", ALL, d4(32'h33), 4'h0, 4'hf, 1'b0, 16'h0);
      tick();
      bus.rd_req = 4'hf; bus.rd_addr = {4'd1, 4'd5, 4'd3, 4'd0};
      expect_out("mixed_ports", ALL, {32'h0, 32'hDEADBEEF, 32'h33, 32'h0}, 4'h0, 4'hf, 1'b0, 16'h0);
      tick();

      // counter saturation on r7
      bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
      expect_out("r7_issue1", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0000);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
      bus.rd_req = 4'h0; bus.rd_addr = a4(4'd7);
      expect_out("r7_issue2_unreq", 5'h1e, '0, 4'h0, 4'h0, 1'b0, 16'h0080);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
      expect_out("r7_issue3", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0080);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd7;
      expect_out("r7_issue4_full", SP, '0, 4'h0, 4'h0, 1'b1, 16'h0080);
      tick();
      for (int w = 1; w <= 3; w++) begin
         bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h7000 + 32'(w);
         expect_out($sformatf("r7_wb%0d", w), SP, '0, 4'h0, 4'h0, 1'b0, 16'h0080);
         tick();
      end
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd7);
      expect_out("r7_drained", ALL, d4(32'h7003), 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();

      // simultaneous issue and wb on r9 leave the count at 1
      bus.issue_en = 1'b1; bus.issue_addr = 4'd9;
      expect_out("r9_issue", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0000);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd9;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd9; bus.wb_data = 32'h99;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd9);
      expect_out("r9_issue_wb", ALL, d4(32'h99), 4'hf, 4'hf, 1'b0, 16'h0200);
      tick();
      bus.rd_req = 4'h1; bus.rd_addr = a4(4'd9);
      expect_out("r9_still_pending", ALL, d4(32'h99), 4'h0, 4'h0, 1'b1, 16'h0200);
      tick();
      bus.wb_en = 1'b1; bus.wb_addr = 4'd9; bus.wb_data = 32'h9a;
      expect_out("r9_wb", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0200);
      tick();
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd9);
      expect_out("r9_clear", ALL, d4(32'h9a), 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();

      // r0 ignores issue, wb and exe
      bus.issue_en = 1'b1; bus.issue_addr = 4'd0;
      bus.wb_en = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 32'hFF;
      bus.exe_en = 1'b1; bus.exe_addr = 4'd0; bus.exe_data = 32'hEE;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd0);
      expect_out("r0_all_ops", ALL, '0, 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd0);
      expect_out("r0_after", ALL, '0, 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();

      // asynchronous reset mid-sequence
      bus.wb_en = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 32'h2222;
      expect_out("r2_wb", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0000);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd2;
      expect_out("r2_issue1", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0000);
      tick();
      bus.issue_en = 1'b1; bus.issue_addr = 4'd2;
      expect_out("r2_issue2", SP, '0, 4'h0, 4'h0, 1'b0, 16'h0004);
      tick();
      rst_n = 1'b0;
      bus.rd_req = 4'h0; bus.rd_addr = a4(4'd2);
      expect_out("r2_async_reset", ALL, '0, 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();
      rst_n = 1'b1;
      bus.rd_req = 4'hf; bus.rd_addr = a4(4'd2);
      expect_out("r2_after_reset", ALL, '0, 4'h0, 4'hf, 1'b0, 16'h0000);
      tick();

      tick();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL leftover expectations got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREGS, default 16, register count (power of 2, >=2); AW = clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 4, read-port count (1..8).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wb_en / wb_addr / wb_data  in  1 / AW / XLEN  writeback commit.
REQ-007 exe_en / exe_addr / exe_data  in  1 / AW / XLEN  execute-stage forward.
REQ-008 issue_en / issue_addr  in  1 / AW  instruction issued; marks destination pending.
REQ-009 rd_req / rd_addr  in  NREAD / NREAD*AW  per-port read request and address (port k at bits [k*AW+:AW]).
REQ-010 rd_data  out  NREAD*XLEN  per-port read value.
REQ-011 rd_fwd  out  NREAD  port k value came from exe or wb bypass.
REQ-012 rd_ready  out  NREAD  port k value is current (not awaiting a pending write).
REQ-013 stall  out  1  OR over k of (rd_req[k] & ~rd_ready[k]).
REQ-014 pending  out  NREGS  scoreboard bit vector, bit 0 always 0.

Function
REQ-015 Register 0 SHALL read as zero; writes, forwards and issues targeting address 0 SHALL be ignored.
REQ-016 Storage write SHALL occur at posedge clk when wb_en & wb_addr!=0; new value visible from storage the next cycle.
REQ-017 Read path SHALL be combinational per port, priority: exe bypass (exe_en, exe_addr==rd_addr, addr!=0) > wb bypass (wb_en, wb_addr==rd_addr, addr!=0) > storage.
REQ-018 rd_fwd[k] SHALL be 1 iff either bypass is selected for port k.
REQ-019 rd_ready[k] SHALL be 1 iff rd_addr[k]==0, or pending[rd_addr[k]]==0, or a bypass is selected for port k.
REQ-020 Each register SHALL hold a 2-bit in-flight counter, saturating at 3; pending[i] = (count[i]!=0).
REQ-021 Per cycle, for address i!=0: issue-only increments; wb-only decrements (no underflow below 0); issue and wb to same i leave count unchanged.
REQ-022 Issue to a register whose count is 3 SHALL NOT change count; stall SHALL be asserted that cycle (structural hazard).
REQ-023 exe forwarding SHALL NOT change the counter; only wb_en clears in-flight state.
REQ-024 Unrequested ports (rd_req[k]=0) SHALL still drive rd_data/rd_fwd/rd_ready but SHALL NOT affect stall.
REQ-025 Same-cycle wb and read of same address SHALL return wb_data via bypass, not stale storage.
REQ-026 Multiple ports reading one address SHALL each return identical values.

Reset
REQ-027 While rst_n=0: all registers 1..NREGS-1 SHALL be 0, all counters 0, pending=0; combinational outputs then follow REQ-017/019 (stall=0 unless bypass-free hazard impossible, i.e. stall=0).
REQ-028 Reset asserted mid-operation SHALL discard in-flight counts immediately; deassertion SHALL be synchronised externally, block needs no internal synchroniser.

Structure
REQ-029 Shared package SHALL hold default XLEN/NREGS/NREAD, AW computation function and the counter-width constant (2).
REQ-030 One sub-module SHALL be instantiated NREAD times: regfile_read_port (bypass mux, rd_fwd, rd_ready).
REQ-031 Counters and storage SHALL reside in the top module; no latches, single always block per state group.

Verification
REQ-032 Reset then read all addresses on 4 ports -> rd_data=0, rd_ready=1111, stall=0, pending=0.
REQ-033 issue r5; next cycle read r5 with rd_req -> rd_ready=0, stall=1; wb r5=0xDEADBEEF -> same cycle rd_data=0xDEADBEEF, rd_fwd=1, ready=1; next cycle pending[5]=0, storage read, rd_fwd=0.
REQ-034 exe r3=0x11, wb r3=0x22, read r3 -> rd_data=0x11; with exe_en=0 -> 0x22.
REQ-035 issue r7 four times with no wb -> count 3, fourth issue raises stall; three wb to r7 -> pending[7]=0 after third.
REQ-036 Simultaneous issue r9 and wb r9 with count 1 -> count stays 1, pending[9]=1; issue/wb/exe to r0 -> r0 reads 0, pending[0]=0.
REQ-037 issue r2 twice, assert rst_n=0 mid-sequence -> pending=0 and r2 reads 0 asynchronously, before next clk edge.
